mmm_engine: RTL and testbench

- Self-sequenced, bit-serial radix-2 Montgomery modular multiplier: R = A·B·2^-WIDTH mod M.
- Generalises the existing fixed datapath. Adds its own sequencing FSM, a start/busy/done handshake, operand latching, an optional final conditional subtraction, and even-modulus error detection.
- Sits under the RSA exponentiation controller, which issues one multiply per start pulse.

---
 rtl/mmm_engine.sv | 179 +++++++++++++++++
 tb/tb_mmm_engine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmm_engine.sv
// Bit-serial radix-2 Montgomery modular multiplier: R = A*B*2^-WIDTH mod M.
// Self-sequenced with start/busy/done handshake, operand latching and even-modulus error flag.
module mmm_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             start,
  input  logic             abort,
  input  logic             skip_sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SW    = WIDTH + 2;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [SW-1:0]    S_ZERO   = {SW{1'b0}};
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [WIDTH-1:0] m_r, m_s;
  logic [WIDTH-1:0] r_r, r_s;
  logic             skip_r, skip_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             err_r, err_s;
  logic [SW-1:0]    acc_r, acc_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;

  // One Montgomery iteration; S < 2M keeps every intermediate below 4M, inside SW bits.
  function automatic logic [SW-1:0] mont_step(
    input logic [SW-1:0]    s,
    input logic             a_bit,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] m
  );
    logic [SW-1:0] t1;
    logic [SW-1:0] t2;
    t1 = a_bit ? (s + {2'b00, b}) : s;
    t2 = t1[0] ? (t1 + {2'b00, m}) : t1;
    return t2 >> 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] final_reduce(
    input logic [SW-1:0]    s,
    input logic [WIDTH-1:0] m,
    input logic             bypass
  );
    if (!bypass && (s >= {2'b00, m})) begin
      return WIDTH'(s - {2'b00, m});
    end else begin
      return WIDTH'(s);
    end
  endfunction

  // Next-state and datapath update; en low holds everything, abort outranks the FSM.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    m_s     = m_r;
    r_s     = r_r;
    skip_s  = skip_r;
    busy_s  = busy_r;
    done_s  = done_r;
    err_s   = err_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    if (!en) begin
      state_s = state_r;
    end else if (abort) begin
      state_s = IDLE;
      acc_s   = S_ZERO;
      cnt_s   = CNT_ZERO;
      busy_s  = 1'b0;
      done_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_s = 1'b0;
          if (start) begin
            a_s    = A;
            b_s    = B;
            m_s    = M;
            skip_s = skip_sub;
            acc_s  = S_ZERO;
            cnt_s  = CNT_ZERO;
            err_s  = 1'b0;
            if (!M[0]) begin
              r_s    = W_ZERO;
              err_s  = 1'b1;
              done_s = 1'b1;
            end else begin
              state_s = CALC;
              busy_s  = 1'b1;
            end
          end else begin
            state_s = IDLE;
          end
        end
        CALC: begin
          // a_r is consumed LSB first by shifting the latched copy
          acc_s = mont_step(acc_r, a_r[0], b_r, m_r);
          a_s   = {1'b0, a_r[WIDTH-1:1]};
          cnt_s = cnt_r + CNT_ONE;
          if (cnt_s == CNT_LAST) begin
            state_s = FINAL;
          end else begin
            state_s = CALC;
          end
        end
        FINAL: begin
          r_s     = final_reduce(acc_r, m_r, skip_r);
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r <= IDLE;
      a_r     <= W_ZERO;
      b_r     <= W_ZERO;
      m_r     <= W_ZERO;
      r_r     <= W_ZERO;
      skip_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      acc_r   <= S_ZERO;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      m_r     <= m_s;
      r_r     <= r_s;
      skip_r  <= skip_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
    end
  end

  assign R    = r_r;
  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_mmm_engine.sv
// Directed and randomized checks of mmm_engine (WIDTH=8 and WIDTH=16) against a
// modular-arithmetic reference model.
module tb_mmm_engine;

  logic        clk = 1'b0;
  logic        rstb;
  logic        en8, start8, abort8, skip8;
  logic [7:0]  a8, b8, m8, r8;
  logic        busy8, done8, err8;
  logic        en16, start16, abort16, skip16;
  logic [15:0] a16, b16, m16, r16;
  logic        busy16, done16, err16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmm_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rstb(rstb), .en(en8), .start(start8), .abort(abort8),
    .skip_sub(skip8), .A(a8), .B(b8), .M(m8), .R(r8),
    .busy(busy8), .done(done8), .err(err8)
  );

  mmm_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .rstb(rstb), .en(en16), .start(start16), .abort(abort16),
    .skip_sub(skip16), .A(a16), .B(b16), .M(m16), .R(r16),
    .busy(busy16), .done(done16), .err(err16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // A*B*2^-w mod m, using (m+1)/2 as the inverse of 2 modulo an odd m
  function automatic longint unsigned mont_ref(input longint unsigned a, input longint unsigned b,
                                               input longint unsigned m, input int w);
    longint unsigned p;
    longint unsigned h;
    h = (m + 64'd1) / 64'd2;
    p = (a * b) % m;
    for (int i = 0; i < w; i++) p = (p * h) % m;
    return p;
  endfunction

  task automatic run_op(input int w, input longint unsigned a, input longint unsigned b,
                        input longint unsigned m, input bit skip,
                        output longint unsigned r, output int lat, output int bcnt);
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; m8 = m[7:0]; skip8 = skip; start8 = 1'b1;
    end else begin
      a16 = a[15:0]; b16 = b[15:0]; m16 = m[15:0]; skip16 = skip; start16 = 1'b1;
    end
    tick();
    start8  = 1'b0;
    start16 = 1'b0;
    lat  = 0;
    bcnt = 0;
    if (w == 8) begin
      if (busy8 === 1'b1) bcnt++;
      while (done8 !== 1'b1 && lat < 64) begin
        tick(); lat++;
        if (busy8 === 1'b1) bcnt++;
      end
      r = 64'(r8);
    end else begin
      if (busy16 === 1'b1) bcnt++;
      while (done16 !== 1'b1 && lat < 64) begin
        tick(); lat++;
        if (busy16 === 1'b1) bcnt++;
      end
      r = 64'(r16);
    end
  endtask

  initial begin
    longint unsigned r, e, m, a, b;
    int lat, bc, n, nen, w;
    bit skip, seen, ok;

    rstb = 1'b0;
    en8 = 1'b1; start8 = 1'b0; abort8 = 1'b0; skip8 = 1'b0; a8 = 8'd0; b8 = 8'd0; m8 = 8'd0;
    en16 = 1'b1; start16 = 1'b0; abort16 = 1'b0; skip16 = 1'b0; a16 = 16'd0; b16 = 16'd0; m16 = 16'd0;
    #12;
    check("rst_r", r8, 0);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_err", err8, 0);
    rstb = 1'b1;
    tick();

    // Run 1: 7*5*2^-8 mod 13 = 1
    run_op(8, 7, 5, 13, 1'b0, r, lat, bc);
    check("t1_r", r, 1);
    check("t1_latency", lat, 9);
    check("t1_busy_cycles", bc, 9);
    check("t1_err", err8, 0);
    check("t1_busy_at_done", busy8, 0);
    tick();
    check("t1_done_pulse", done8, 0);

    // Zero operand, then back-to-back with start held through FINAL
    run_op(8, 0, 12, 13, 1'b0, r, lat, bc);
    check("t2_zero", r, 0);
    a8 = 8'd12; b8 = 8'd12; m8 = 8'd13; skip8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (8) tick();
    check("t2_final_busy", busy8, 1);
    a8 = 8'd7; b8 = 8'd5; start8 = 1'b1;
    tick();
    check("t2_done", done8, 1);
    check("t2_r", r8, 3);
    check("t2_busy_low", busy8, 0);
    tick();
    start8 = 1'b0;
    check("t2_accept_busy", busy8, 1);
    check("t2_accept_done", done8, 0);
    lat = 0;
    while (done8 !== 1'b1 && lat < 64) begin tick(); lat++; end
    check("t2_b2b_r", r8, 1);
    check("t2_b2b_latency", lat, 9);

    // Even modulus
    a8 = 8'd3; b8 = 8'd4; m8 = 8'd12; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("t3_done", done8, 1);
    check("t3_err", err8, 1);
    check("t3_r", r8, 0);
    check("t3_busy", busy8, 0);
    tick();
    check("t3_done_clear", done8, 0);
    check("t3_err_hold", err8, 1);
    run_op(8, 7, 5, 13, 1'b0, r, lat, bc);
    check("t3_err_cleared", err8, 0);
    check("t3_r_after", r, 1);

    // Enable toggled at random during run 1
    a8 = 8'd7; b8 = 8'd5; m8 = 8'd13; skip8 = 1'b0; en8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0; nen = 0;
    while (done8 !== 1'b1 && n < 200) begin
      en8 = 1'($urandom_range(0, 1));
      tick(); n++;
      if (en8) nen++;
    end
    check("t5_done", done8, 1);
    check("t5_en_edges", nen, 9);
    check("t5_r", r8, 1);
    en8 = 1'b0;
    repeat (3) tick();
    check("t5_done_held", done8, 1);
    check("t5_busy_low", busy8, 0);
    en8 = 1'b1;
    tick();
    check("t5_done_clear", done8, 0);

    // Abort at iteration 4
    a8 = 8'd12; b8 = 8'd12; m8 = 8'd13; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    abort8 = 1'b1;
    tick();
    abort8 = 1'b0;
    check("t6_abort_busy", busy8, 0);
    check("t6_abort_done", done8, 0);
    check("t6_abort_r_hold", r8, 1);
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (done8 === 1'b1 || busy8 === 1'b1) seen = 1'b1;
    end
    check("t6_no_done", seen, 0);
    start8 = 1'b1; abort8 = 1'b1;
    tick();
    start8 = 1'b0; abort8 = 1'b0;
    check("t6_abort_start_busy", busy8, 0);
    check("t6_abort_start_done", done8, 0);
    tick();
    check("t6_not_accepted", busy8, 0);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    check("t6_midcalc_busy", busy8, 1);
    rstb = 1'b0;
    #1;
    check("t6_rst_r", r8, 0);
    check("t6_rst_busy", busy8, 0);
    check("t6_rst_done", done8, 0);
    check("t6_rst_err", err8, 0);
    #3;
    rstb = 1'b1;
    tick();

    // Randomized operands on both widths
    for (int i = 0; i < 24; i++) begin
      w = (i % 2 == 0) ? 8 : 16;
      skip = 1'($urandom_range(0, 1));
      if (w == 8) m = skip ? 64'($urandom_range(3, 127)) : 64'($urandom_range(3, 255));
      else        m = skip ? 64'($urandom_range(3, 32767)) : 64'($urandom_range(3, 65535));
      m = m | 64'd1;
      a = 64'($urandom_range(0, 32'(m - 64'd1)));
      b = 64'($urandom_range(0, 32'(m - 64'd1)));
      e = mont_ref(a, b, m, w);
      run_op(w, a, b, m, skip, r, lat, bc);
      check("rnd_latency", lat, w + 1);
      if (!skip) begin
        check("rnd_exact", r, e);
      end else begin
        ok = (r == e) || (r == e + m);
        check("rnd_skip_congruent", ok, 1);
        check("rnd_skip_lt_2m", (r < 2 * m), 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
